adma_chn_arb: RTL and testbench

- Weighted round-robin arbiter sharing the DMA's single AXI transaction path between DMA_CHN_NUM channels.
- Sits between the per-channel request logic in the channel manager and the AXI transaction scheduler.
- Issues one grant per transaction with a valid/ready handshake.
- A channel with weight w may win up to w consecutive grants before priority rotates; w=0 masks the channel.

---
 rtl/adma_chn_arb.sv | 134 +++++++++++++
 tb/tb_adma_chn_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adma_chn_arb.sv
// Weighted round-robin arbiter: one AXI transaction grant at a time among DMA channels.
// Latency: a grant is presented 1 cycle after an eligible request is sampled in IDLE.
// Backpressure: the grant is held stable until gnt_rdy_i; then 1 idle cycle before the next grant.
module adma_chn_arb #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int DMA_CHN_ARB_W = 3,
  parameter int CHN_ID_W      = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic                                   arb_en_i,
  input  logic [DMA_CHN_NUM-1:0]                 chn_req_i,
  input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]   chn_wgt_i,
  output logic                                   gnt_vld_o,
  input  logic                                   gnt_rdy_i,
  output logic [CHN_ID_W-1:0]                    gnt_id_o,
  output logic [DMA_CHN_NUM-1:0]                 chn_gnt_o,
  output logic [DMA_CHN_ARB_W-1:0]               gnt_cnt_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CHN_ID_W-1:0] PTR_RST = CHN_ID_W'(DMA_CHN_NUM - 1);

  logic [0:0]               state;
  // ptr always names the most recent winner, so it doubles as the granted index.
  logic [CHN_ID_W-1:0]      ptr;
  // Consecutive grants already given to ptr; 0 means no owner run is in progress.
  logic [DMA_CHN_ARB_W-1:0] credit;

  logic [DMA_CHN_NUM-1:0]   elig;
  logic                     any_elig;
  logic                     ptr_elig;
  logic [DMA_CHN_ARB_W-1:0] ptr_wgt;
  logic                     stay;
  logic [CHN_ID_W-1:0]      rot_id;
  logic                     rot_found;
  logic [CHN_ID_W-1:0]      sel_id;
  logic [DMA_CHN_ARB_W-1:0] sel_cnt;
  logic                     start_gnt;

  // Eligibility: requesting and not masked by a zero weight.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      elig[i] = chn_req_i[i] && (chn_wgt_i[i*DMA_CHN_ARB_W +: DMA_CHN_ARB_W] != '0);
    end
  end

  assign any_elig = |elig;

  // Look up the current owner's live weight and eligibility.
  always_comb begin
    ptr_wgt  = '0;
    ptr_elig = 1'b0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      if (ptr == CHN_ID_W'(i)) begin
        ptr_wgt  = chn_wgt_i[i*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
        ptr_elig = elig[i];
      end
    end
  end

  // The owner keeps the grant only while it has an active run and credit below its weight.
  // Requiring credit != 0 makes the reset pointer (last channel) lose to channel 0 first.
  assign stay = ptr_elig && (credit != '0) && (credit < ptr_wgt);

  // Rotating search starting after ptr, wrapping, with ptr itself as the last candidate.
  always_comb begin
    int idx;
    rot_id    = ptr;
    rot_found = 1'b0;
    for (int k = 1; k <= DMA_CHN_NUM; k++) begin
      idx = (int'(ptr) + k) % DMA_CHN_NUM;
      if (!rot_found && elig[idx]) begin
        rot_found = 1'b1;
        rot_id    = CHN_ID_W'(idx);
      end
    end
  end

  // Winner and resulting run length for the next grant.
  always_comb begin
    if (stay) begin
      sel_id  = ptr;
      sel_cnt = credit + DMA_CHN_ARB_W'(1);
    end else begin
      sel_id  = rot_id;
      sel_cnt = DMA_CHN_ARB_W'(1);
    end
  end

  assign start_gnt = (state == IDLE) && arb_en_i && any_elig;

  // Arbitration FSM: ptr/credit only change when a new grant is issued.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      ptr    <= PTR_RST;
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_gnt) begin
            state  <= GRANT;
            ptr    <= sel_id;
            credit <= sel_cnt;
          end
        end
        GRANT: begin
          // Never retracted: only the handshake ends a grant.
          if (gnt_rdy_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_vld_o = (state == GRANT);
  assign gnt_id_o  = gnt_vld_o ? ptr : '0;
  assign gnt_cnt_o = gnt_vld_o ? credit : '0;

  // One-hot grant, forced to zero outside GRANT.
  always_comb begin
    chn_gnt_o = '0;
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      chn_gnt_o[i] = gnt_vld_o && (ptr == CHN_ID_W'(i));
    end
  end

endmodule

// File: tb/tb_adma_chn_arb.sv
// Bench for adma_chn_arb: directed scenarios plus random traffic against a transaction model.
// Latency: outputs compared each cycle on the falling edge.
// Backpressure: gnt_rdy_i driven both directed and randomly.
module tb_adma_chn_arb;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int IW = 2;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b1;
  logic           arb_en = 1'b0;
  logic [N-1:0]   chn_req = '0;
  logic [N*W-1:0] chn_wgt = '0;
  logic           gnt_rdy = 1'b0;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_id;
  logic [N-1:0]   chn_gnt;
  logic [W-1:0]   gnt_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model: busy flag, current owner and its run length.
  int m_busy;
  int m_ptr;
  int m_cred;

  adma_chn_arb #(.DMA_CHN_NUM(N), .DMA_CHN_ARB_W(W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .arb_en_i  (arb_en),
    .chn_req_i (chn_req),
    .chn_wgt_i (chn_wgt),
    .gnt_vld_o (gnt_vld),
    .gnt_rdy_i (gnt_rdy),
    .gnt_id_o  (gnt_id),
    .chn_gnt_o (chn_gnt),
    .gnt_cnt_o (gnt_cnt)
  );

  always #5 aclk = ~aclk;

  function automatic int wgt_of(int i);
    return int'(chn_wgt[i*W +: W]);
  endfunction

  function automatic bit elig(int i);
    return chn_req[i] && (wgt_of(i) != 0);
  endfunction

  task automatic set_wgt(int w0, int w1, int w2, int w3);
    chn_wgt = {W'(w3), W'(w2), W'(w1), W'(w0)};
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_ptr  = N - 1;
    m_cred = 0;
  endtask

  // One rising edge of the arbiter as seen at transaction level.
  task automatic model_edge();
    if (m_busy != 0) begin
      if (gnt_rdy) m_busy = 0;
    end else if (arb_en) begin
      if (m_cred > 0 && elig(m_ptr) && m_cred < wgt_of(m_ptr)) begin
        m_cred++;
        m_busy = 1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (elig((m_ptr + k) % N)) begin
            m_ptr  = (m_ptr + k) % N;
            m_cred = 1;
            m_busy = 1;
            break;
          end
        end
      end
    end
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".vld"}, 32'(gnt_vld), (m_busy != 0) ? 32'd1 : 32'd0);
    chk({tag, ".id"},  32'(gnt_id),  (m_busy != 0) ? 32'(m_ptr) : 32'd0);
    chk({tag, ".oh"},  32'(chn_gnt), (m_busy != 0) ? (32'd1 << m_ptr) : 32'd0);
    chk({tag, ".cnt"}, 32'(gnt_cnt), (m_busy != 0) ? 32'(m_cred) : 32'd0);
  endtask

  task automatic step(string tag);
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    check_outs(tag);
  endtask

  // Assert reset (outputs must clear at once), release on the next falling edge.
  task automatic do_reset();
    aresetn = 1'b0;
    model_reset();
    #1;
    check_outs("rst");
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    int exp_seq[8];
    int exp_cnt[8];
    int got;
    int exp_next;

    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_cnt = '{1, 2, 3, 1, 1, 2, 3, 1};

    #2;
    do_reset();

    // All requesting, unit weights: grants rotate 0,1,2,3,0 every two cycles.
    arb_en  = 1'b1;
    gnt_rdy = 1'b1;
    chn_req = 4'b1111;
    set_wgt(1, 1, 1, 1);
    for (int c = 0; c < 12; c++) step("rr");

    // Weighted: ch0 weight 3, ch1 weight 1.
    do_reset();
    chn_req = 4'b0011;
    set_wgt(3, 1, 0, 0);
    got = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      step("wrr");
      if (gnt_vld) begin
        chk("wrr.seq", 32'(gnt_id), 32'(exp_seq[got]));
        chk("wrr.cntseq", 32'(gnt_cnt), 32'(exp_cnt[got]));
        got++;
      end
    end
    chk("wrr.count", 32'(got), 32'd8);

    // Zero weight masks ch2.
    chn_req = 4'b0101;
    set_wgt(2, 1, 0, 1);
    for (int c = 0; c < 10; c++) begin
      step("mask");
      chk("mask.no_ch2", 32'(chn_gnt[2]), 32'd0);
    end

    // Grant to ch1 held under backpressure while its request drops.
    do_reset();
    set_wgt(1, 1, 1, 1);
    chn_req = 4'b0010;
    gnt_rdy = 1'b0;
    step("hold");
    chk("hold.first_id", 32'(gnt_id), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) chn_req = 4'b0000;
      step("hold");
      chk("hold.vld", 32'(gnt_vld), 32'd1);
      chk("hold.id", 32'(gnt_id), 32'd1);
      chk("hold.oh", 32'(chn_gnt), 32'b0010);
    end
    gnt_rdy = 1'b1;
    chn_req = 4'b0100;
    step("hs");
    chk("hs.gap", 32'(gnt_vld), 32'd0);
    step("hs2");
    chk("hs2.next", 32'(gnt_vld), 32'd1);

    // Disabled: no grants for 10 cycles, then continue from ptr+1.
    arb_en  = 1'b0;
    chn_req = 4'b1111;
    step("dis_hs");
    for (int c = 0; c < 10; c++) begin
      step("dis");
      chk("dis.vld", 32'(gnt_vld), 32'd0);
    end
    exp_next = (m_ptr + 1) % N;
    arb_en = 1'b1;
    step("en");
    chk("en.id", 32'(gnt_id), 32'(exp_next));

    // Reset pulsed during an outstanding grant.
    gnt_rdy = 1'b0;
    for (int c = 0; c < 4 && !gnt_vld; c++) step("pre_rst");
    chk("pre_rst.vld", 32'(gnt_vld), 32'd1);
    aresetn = 1'b0;
    model_reset();
    #1;
    check_outs("mid_rst");
    chn_req = 4'b1000;
    gnt_rdy = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    step("post_rst");
    chk("post_rst.id", 32'(gnt_id), 32'd3);
    chk("post_rst.cnt", 32'(gnt_cnt), 32'd1);

    // Random traffic with changing weights, enable and backpressure.
    for (int c = 0; c < 600; c++) begin
      chn_req = N'($urandom);
      if ($urandom_range(0, 7) == 0) chn_wgt = (N*W)'($urandom);
      arb_en  = ($urandom_range(0, 9) != 0);
      gnt_rdy = ($urandom_range(0, 9) < 7);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
